mig_ui_bram_responder: RTL and testbench

Synthesizable stand-in for the DDR3 MIG user interface (UI). It answers app_* write and read commands from the DDR test/FIFO bridge using on-chip block RAM instead of external DDR3. It is used in DDR-less builds and benches to exercise the initiator's handshakes: calibration delay, app_rdy/app_wdf_rdy backpressure and read latency.

---
 rtl/mig_ui_bram_responder.sv | 178 +++++++++++++++++
 tb/tb_mig_ui_bram_responder.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_ui_bram_responder.sv
// Block-RAM stand-in for the DDR3 MIG user interface: app_* commands and
// write data are served from on-chip memory with emulated calibration.
module mig_ui_bram_responder #(
  parameter int DEPTH_LOG2     = 10,
  parameter int CALIB_CYCLES   = 64,
  parameter int RD_LATENCY     = 4,
  parameter int WDF_DEPTH_LOG2 = 2,
  parameter int BUSY_PERIOD    = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         app_en,
  input  logic [2:0]   app_cmd,
  input  logic [29:0]  app_addr,
  output logic         app_rdy,
  input  logic         app_wdf_wren,
  input  logic [255:0] app_wdf_data,
  input  logic         app_wdf_end,
  input  logic [31:0]  app_wdf_mask,
  output logic         app_wdf_rdy,
  output logic [255:0] app_rd_data,
  output logic         app_rd_data_valid,
  output logic         app_rd_data_end,
  output logic         init_calib_complete,
  output logic [31:0]  wr_cmd_count,
  output logic [31:0]  rd_cmd_count,
  output logic [2:0]   err_flags
);

  localparam int DEPTH     = 1 << DEPTH_LOG2;
  localparam int WDF_DEPTH = 1 << WDF_DEPTH_LOG2;
  localparam int CW        = $clog2(CALIB_CYCLES + 1);
  localparam int TW        = (BUSY_PERIOD > 2) ? $clog2(BUSY_PERIOD) : 1;
  localparam int FW        = WDF_DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] word_t;

  logic [255:0] mem [DEPTH];
  logic [255:0] fifo_data [WDF_DEPTH];
  logic [31:0]  fifo_mask [WDF_DEPTH];
  logic [255:0] ram_rd_q;

  logic          calib_q, calib_d;
  logic [CW-1:0] cal_cnt_q, cal_cnt_d;
  logic [TW-1:0] thr_cnt_q, thr_cnt_d;
  logic          pend_q, pend_d;
  word_t         pend_addr_q, pend_addr_d;
  logic [FW-1:0] wptr_q, wptr_d;
  logic [FW-1:0] rptr_q, rptr_d;
  logic [FW:0]   fcnt_q, fcnt_d;
  logic [31:0]   wr_cnt_q, wr_cnt_d;
  logic [31:0]   rd_cnt_q, rd_cnt_d;
  logic [2:0]    err_q, err_d;

  logic [RD_LATENCY-1:0]        rd_vld_q, rd_vld_d;
  logic [RD_LATENCY-1:1][255:0] rd_pipe_q, rd_pipe_d;

  logic  throttle, fifo_full, fifo_ne;
  logic  acc, is_wr, is_rd, push, commit, rd_acc;
  word_t acc_word, cm_addr;

  logic unused_addr;
  assign unused_addr = ^app_addr[29:DEPTH_LOG2+3];

  always_comb begin
    throttle = (BUSY_PERIOD > 1) &&
               (thr_cnt_q == TW'(BUSY_PERIOD - 1));
    fifo_full = (fcnt_q == (FW+1)'(WDF_DEPTH));
    fifo_ne   = (fcnt_q != '0);

    app_rdy     = calib_q & ~pend_q & ~throttle;
    app_wdf_rdy = calib_q & ~fifo_full;

    acc      = app_en & app_rdy & ~reset;
    acc_word = app_addr[DEPTH_LOG2+2:3];
    is_wr    = (app_cmd == 3'b000);
    is_rd    = (app_cmd == 3'b001);
    push     = app_wdf_wren & app_wdf_rdy & ~reset;
    rd_acc   = acc & is_rd;

    // A pending write only needs FIFO data; it never coincides with an accept.
    commit  = (acc & is_wr & fifo_ne) | (pend_q & fifo_ne & ~reset);
    cm_addr = pend_q ? pend_addr_q : acc_word;

    cal_cnt_d = calib_q ? cal_cnt_q : cal_cnt_q + 1'b1;
    calib_d   = calib_q | (cal_cnt_q == CW'(CALIB_CYCLES - 1));

    thr_cnt_d = '0;
    if (BUSY_PERIOD > 1)
      thr_cnt_d = throttle ? '0 : thr_cnt_q + 1'b1;

    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    if (acc & is_wr & ~fifo_ne) begin
      pend_d      = 1'b1;
      pend_addr_d = acc_word;
    end else if (pend_q & commit) begin
      pend_d = 1'b0;
    end

    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = commit ? rptr_q + 1'b1 : rptr_q;
    fcnt_d = fcnt_q;
    if (push & ~commit)
      fcnt_d = fcnt_q + 1'b1;
    else if (~push & commit)
      fcnt_d = fcnt_q - 1'b1;

    wr_cnt_d = wr_cnt_q + 32'(commit);
    rd_cnt_d = rd_cnt_q + 32'(rd_acc);

    err_d = err_q | {app_wdf_wren ^ app_wdf_end,
                     acc & ~is_wr & ~is_rd,
                     acc & (app_addr[2:0] != 3'b000)};

    rd_vld_d     = {rd_vld_q[RD_LATENCY-2:0], rd_acc};
    rd_pipe_d    = rd_pipe_q;
    rd_pipe_d[1] = ram_rd_q;
    for (int i = 2; i < RD_LATENCY; i++)
      rd_pipe_d[i] = rd_pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      calib_q     <= 1'b0;
      cal_cnt_q   <= '0;
      thr_cnt_q   <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      fcnt_q      <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      err_q       <= '0;
      rd_vld_q    <= '0;
      rd_pipe_q   <= '0;
    end else begin
      calib_q     <= calib_d;
      cal_cnt_q   <= cal_cnt_d;
      thr_cnt_q   <= thr_cnt_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      fcnt_q      <= fcnt_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      err_q       <= err_d;
      rd_vld_q    <= rd_vld_d;
      rd_pipe_q   <= rd_pipe_d;
    end
  end

  // Storage has no reset so RAM contents survive a reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wptr_q] <= app_wdf_data;
      fifo_mask[wptr_q] <= app_wdf_mask;
    end
    if (commit) begin
      for (int b = 0; b < 32; b++)
        if (!fifo_mask[rptr_q][b])
          mem[cm_addr][b*8 +: 8] <= fifo_data[rptr_q][b*8 +: 8];
    end
    if (rd_acc)
      ram_rd_q <= mem[acc_word];
  end

  assign app_rd_data         = rd_pipe_q[RD_LATENCY-1];
  assign app_rd_data_valid   = rd_vld_q[RD_LATENCY-1];
  assign app_rd_data_end     = rd_vld_q[RD_LATENCY-1];
  assign init_calib_complete = calib_q;
  assign wr_cmd_count        = wr_cnt_q;
  assign rd_cmd_count        = rd_cnt_q;
  assign err_flags           = err_q;

endmodule

// File: tb/tb_mig_ui_bram_responder.sv
// Bench for mig_ui_bram_responder: queue-based UI model compared every
// cycle, directed scenarios with literal expectations, throttled instance.
module tb_mig_ui_bram_responder;

  localparam int CAL = 64;
  localparam int RL  = 4;
  localparam int FD  = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         app_en;
  logic [2:0]   app_cmd;
  logic [29:0]  app_addr;
  logic         app_rdy;
  logic         app_wdf_wren;
  logic [255:0] app_wdf_data;
  logic         app_wdf_end;
  logic [31:0]  app_wdf_mask;
  logic         app_wdf_rdy;
  logic [255:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         init_calib_complete;
  logic [31:0]  wr_cmd_count;
  logic [31:0]  rd_cmd_count;
  logic [2:0]   err_flags;

  logic         t_en;
  logic [2:0]   t_cmd;
  logic [29:0]  t_addr;
  logic         t_rdy, t_wdf_rdy, t_vld, t_end, t_calib;
  logic [255:0] t_data;
  logic [31:0]  t_wrc, t_rdc;
  logic [2:0]   t_err;

  always #5 clk = ~clk;

  mig_ui_bram_responder u_dut (
    .clk(clk), .reset(reset),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data),
    .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
    .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end),
    .init_calib_complete(init_calib_complete),
    .wr_cmd_count(wr_cmd_count), .rd_cmd_count(rd_cmd_count),
    .err_flags(err_flags)
  );

  mig_ui_bram_responder #(.CALIB_CYCLES(8), .BUSY_PERIOD(4)) u_thr (
    .clk(clk), .reset(reset),
    .app_en(t_en), .app_cmd(t_cmd), .app_addr(t_addr),
    .app_rdy(t_rdy),
    .app_wdf_wren(1'b0), .app_wdf_data(256'd0),
    .app_wdf_end(1'b0), .app_wdf_mask(32'd0),
    .app_wdf_rdy(t_wdf_rdy),
    .app_rd_data(t_data), .app_rd_data_valid(t_vld),
    .app_rd_data_end(t_end),
    .init_calib_complete(t_calib),
    .wr_cmd_count(t_wrc), .rd_cmd_count(t_rdc),
    .err_flags(t_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: FIFO/read queues and a sparse memory image.
  typedef struct { logic [255:0] d; logic [31:0] m; } wd_t;
  typedef struct { int due; logic [255:0] d; } rd_t;

  wd_t          m_fq[$];
  rd_t          m_rq[$];
  logic [255:0] m_mem [int];
  bit           m_init = 0;
  int           m_cyc;
  bit           m_pend;
  int           m_paddr;
  logic [31:0]  m_wrc, m_rdc;
  logic [2:0]   m_err;

  task automatic m_commit(input int w);
    wd_t h;
    logic [255:0] t;
    h = m_fq.pop_front();
    t = m_mem.exists(w) ? m_mem[w] : 'x;
    for (int b = 0; b < 32; b++)
      if (!h.m[b]) t[b*8 +: 8] = h.d[b*8 +: 8];
    m_mem[w] = t;
    m_wrc++;
  endtask

  always @(negedge clk) begin
    logic e_cal, e_rdy, e_wrdy, e_vld, ne;
    int   w;
    rd_t  r;
    wd_t  p;
    e_cal = 0; e_rdy = 0; e_wrdy = 0; e_vld = 0;
    if (m_init) begin
      e_cal  = (m_cyc >= CAL);
      e_rdy  = e_cal && !m_pend;
      e_wrdy = e_cal && (m_fq.size() < FD);
      e_vld  = (m_rq.size() > 0) && (m_rq[0].due == m_cyc);
      chk("m_calib", init_calib_complete, e_cal);
      chk("m_app_rdy", app_rdy, e_rdy);
      chk("m_wdf_rdy", app_wdf_rdy, e_wrdy);
      chk("m_rd_valid", app_rd_data_valid, e_vld);
      chk("m_rd_end", app_rd_data_end, e_vld);
      chk("m_wr_count", wr_cmd_count, m_wrc);
      chk("m_rd_count", rd_cmd_count, m_rdc);
      chk("m_err_flags", err_flags, m_err);
      if (e_vld && !$isunknown(m_rq[0].d))
        chk("m_rd_data", app_rd_data, m_rq[0].d);
    end
    if (reset) begin
      m_init = 1; m_cyc = 0; m_pend = 0;
      m_fq.delete(); m_rq.delete();
      m_wrc = 0; m_rdc = 0; m_err = 0;
    end else if (m_init) begin
      ne = (m_fq.size() > 0);
      w  = int'(app_addr[12:3]);
      if (app_wdf_wren != app_wdf_end) m_err[2] = 1'b1;
      if (app_en && e_rdy) begin
        if (app_addr[2:0] != 3'b000) m_err[0] = 1'b1;
        case (app_cmd)
          3'b000: begin
            if (ne) m_commit(w);
            else begin m_pend = 1; m_paddr = w; end
          end
          3'b001: begin
            r.due = m_cyc + RL;
            r.d   = m_mem.exists(w) ? m_mem[w] : 'x;
            m_rq.push_back(r);
            m_rdc++;
          end
          default: m_err[1] = 1'b1;
        endcase
      end else if (m_pend && ne) begin
        m_commit(m_paddr);
        m_pend = 0;
      end
      if (app_wdf_wren && e_wrdy) begin
        p.d = app_wdf_data; p.m = app_wdf_mask;
        m_fq.push_back(p);
      end
      if (e_vld) void'(m_rq.pop_front());
      m_cyc++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [255:0] d, input logic [31:0] m);
    app_wdf_wren = 1; app_wdf_end = 1;
    app_wdf_data = d; app_wdf_mask = m;
    tick();
    app_wdf_wren = 0; app_wdf_end = 0;
  endtask

  task automatic do_cmd(input logic [2:0] c, input logic [29:0] a);
    bit ok;
    ok = 0;
    app_en = 1; app_cmd = c; app_addr = a;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (app_rdy) begin ok = 1; break; end
      tick();
    end
    chk("cmd_accept_timeout", ok, 1);
    tick();
    app_en = 0;
  endtask

  task automatic wait_rd(output int lat, output logic [255:0] d,
                         output logic e);
    bit got;
    got = 0; lat = 0; d = '0; e = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (app_rd_data_valid) begin
        got = 1; d = app_rd_data; e = app_rd_data_end;
        break;
      end
      tick();
    end
    chk("rd_timeout", got, 1);
    tick();
  endtask

  task automatic do_reset();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  task automatic wait_calib();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (init_calib_complete) begin ok = 1; break; end
      tick();
    end
    chk("calib_timeout", ok, 1);
    tick();
  endtask

  initial begin
    int           lat, lows, accs, tv;
    logic [255:0] d, d1, ex, wd;
    logic         e;

    reset = 1; app_en = 0; app_cmd = 0; app_addr = 0;
    app_wdf_wren = 0; app_wdf_end = 0;
    app_wdf_data = 0; app_wdf_mask = 0;
    t_en = 0; t_cmd = 0; t_addr = 0;
    repeat (3) tick();
    reset = 0;

    // Calibration window: cycles 0..63 idle, cycle 64 ready.
    for (int i = 0; i < CAL; i++) begin
      @(negedge clk);
      if (i == 0 || i == CAL - 1) begin
        chk("cal_low", init_calib_complete, 0);
        chk("rdy_low", app_rdy, 0);
        chk("wdf_rdy_low", app_wdf_rdy, 0);
      end
      tick();
    end
    @(negedge clk);
    chk("cal_high", init_calib_complete, 1);
    chk("rdy_high", app_rdy, 1);
    chk("wdf_rdy_high", app_wdf_rdy, 1);
    chk("wr_cnt_reset", wr_cmd_count, 0);
    chk("rd_cnt_reset", rd_cmd_count, 0);
    tick();

    // Data first, then write command, then read back.
    push({32{8'hA5}}, 32'h0);
    do_cmd(3'b000, 30'h10);
    do_cmd(3'b001, 30'h10);
    wait_rd(lat, d, e);
    chk("rd_latency", lat, 4);
    chk("rd_data_a5", d, {32{8'hA5}});
    chk("rd_end", e, 1);
    chk("wr_cnt_1", wr_cmd_count, 1);
    chk("rd_cnt_1", rd_cmd_count, 1);

    // Write command with empty FIFO stalls until data arrives.
    d1 = {8{32'h1234_5678}};
    do_cmd(3'b000, 30'h8);
    @(negedge clk); chk("pend_rdy_low1", app_rdy, 0); tick();
    @(negedge clk); chk("pend_rdy_low2", app_rdy, 0); tick();
    push(d1, 32'h0);
    @(negedge clk); chk("commit_rdy_low", app_rdy, 0); tick();
    @(negedge clk); chk("pend_rdy_back", app_rdy, 1);
    chk("wr_cnt_2", wr_cmd_count, 2);
    tick();
    do_cmd(3'b001, 30'h8);
    wait_rd(lat, d, e);
    chk("rd_data_pend", d, d1);

    // Masked overwrite: only byte 0 changes.
    push({32{8'hFF}}, 32'hFFFF_FFFE);
    do_cmd(3'b000, 30'h8);
    do_cmd(3'b001, 30'h8);
    wait_rd(lat, d, e);
    ex = d1;
    ex[7:0] = 8'hFF;
    chk("rd_data_mask", d, ex);

    // FIFO fill to depth, overflow drop, drain by four commands.
    do_reset();
    wait_calib();
    for (int i = 0; i < FD; i++) begin
      wd = {8{32'hC0DE_0000 | 32'(i)}};
      push(wd, 32'h0);
    end
    @(negedge clk);
    chk("fifo_full_rdy", app_wdf_rdy, 0);
    tick();
    push({8{32'hDEAD_BEEF}}, 32'h0);
    for (int i = 0; i < FD; i++)
      do_cmd(3'b000, 30'(32'h100 + 8 * i));
    @(negedge clk);
    chk("fifo_drain_wr_cnt", wr_cmd_count, 4);
    chk("fifo_drain_rdy", app_wdf_rdy, 1);
    tick();
    do_cmd(3'b001, 30'h118);
    wait_rd(lat, d, e);
    chk("fifo_last_word", d, {8{32'hC0DE_0003}});

    // Throttled instance: held reads, one busy cycle in four.
    @(negedge clk);
    chk("thr_calib", t_calib, 1);
    tick();
    t_en = 1; t_cmd = 3'b001; t_addr = 30'h0;
    lows = 0; accs = 0; tv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (t_rdy) accs++; else lows++;
      if (t_vld) tv++;
      tick();
    end
    t_en = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (t_vld) tv++;
      tick();
    end
    chk("thr_low_cycles", lows, 10);
    chk("thr_accepts", accs, 30);
    chk("thr_rd_cnt", t_rdc, 30);
    chk("thr_valids", tv, 30);

    // Sticky error flags.
    do_cmd(3'b001, 30'h3);
    @(negedge clk); chk("err_misalign", err_flags, 3'b001); tick();
    do_cmd(3'b010, 30'h20);
    @(negedge clk); chk("err_invalid", err_flags, 3'b011); tick();
    app_wdf_end = 1;
    tick();
    app_wdf_end = 0;
    @(negedge clk); chk("err_wdf_end", err_flags, 3'b111); tick();
    repeat (6) tick();

    // Reset with a read in flight: no valid, flags cleared.
    do_cmd(3'b001, 30'h10);
    tick();
    do_reset();
    tv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (app_rd_data_valid) tv++;
      tick();
    end
    chk("rst_no_valid", tv, 0);
    chk("rst_err_clear", err_flags, 0);
    chk("rst_rd_cnt", rd_cmd_count, 0);

    // RAM contents survive reset.
    wait_calib();
    do_cmd(3'b001, 30'h10);
    wait_rd(lat, d, e);
    chk("ram_kept", d, {32{8'hA5}});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
